// File: rtl/router_reset_ctrl.sv
// router_reset_ctrl: router reset sequencer with synchronized POR release, minimum hold and soft-reset handshake
module router_reset_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic             router_reset,
  output logic             reset_done,
  output logic [CNT_W-1:0] sw_rst_count
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [2:0] {POR_SYNC, POR_HOLD, RUN, SW_HOLD, SW_ACK} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync, sync_nxt;
  logic [HW-1:0] cnt, cnt_nxt;
  logic hold_end;
  assign sync_nxt = {sync[SYNC_STAGES-2:0], 1'b1};
  assign hold_end = cnt == HW'(HOLD_CYCLES - 1);
  // Leave POR_SYNC on the edge that fills the last synchronizer stage
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    case (state)
      POR_SYNC: state_nxt = sync_nxt[SYNC_STAGES-1] ? POR_HOLD : POR_SYNC;
      POR_HOLD: begin
        cnt_nxt = cnt + 1'b1;
        state_nxt = hold_end ? RUN : POR_HOLD;
      end
      RUN:     state_nxt = sw_rst_req ? SW_HOLD : RUN;
      SW_HOLD: begin
        cnt_nxt = cnt + 1'b1;
        state_nxt = hold_end ? SW_ACK : SW_HOLD;
      end
      SW_ACK:  state_nxt = sw_rst_req ? SW_ACK : RUN;
      default: state_nxt = POR_SYNC;
    endcase
  end
  // Outputs are registered copies of the next-state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= POR_SYNC;
      sync <= '0;
      cnt <= '0;
      router_reset <= 1'b1;
      reset_done <= 1'b0;
      sw_rst_ack <= 1'b0;
      sw_rst_count <= '0;
    end else begin
      state <= state_nxt;
      sync <= sync_nxt;
      cnt <= cnt_nxt;
      router_reset <= state_nxt == POR_SYNC || state_nxt == POR_HOLD || state_nxt == SW_HOLD;
      reset_done <= state_nxt == RUN;
      sw_rst_ack <= state_nxt == SW_ACK;
      sw_rst_count <= (state == SW_HOLD && hold_end && !(&sw_rst_count)) ? sw_rst_count + 1'b1 : sw_rst_count;
    end
  end
endmodule

// File: tb/tb_router_reset_ctrl.sv
// tb_router_reset_ctrl: directed table, corner sequences and random checks against a deadline-based reference model
module tb_router_reset_ctrl;
  localparam int S = 2;
  localparam int H = 16;
  localparam int P = S + H;
  logic clk = 0;
  logic reset = 0;
  logic req = 0;
  logic ack, rr, done, ack2, rr2, done2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int n_chk = 0;
  int n_pass = 0;
  router_reset_ctrl u_dut (
    .clk(clk), .reset(reset), .sw_rst_req(req), .sw_rst_ack(ack),
    .router_reset(rr), .reset_done(done), .sw_rst_count(cnt)
  );
  router_reset_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .sw_rst_req(req), .sw_rst_ack(ack2),
    .router_reset(rr2), .reset_done(done2), .sw_rst_count(cnt2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  // Reference: edges since release, absolute hold deadline, and a handshake phase
  int m_t = 0;
  int m_mode = 0;
  int m_until = 0;
  int m_cnt = 0;
  bit m_rr = 1, m_done = 0, m_ack = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t <= 0; m_mode <= 0; m_cnt <= 0; m_rr <= 1; m_done <= 0; m_ack <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == P) begin
        m_rr <= 0; m_done <= 1; m_mode <= 1;
      end else if (m_mode == 1 && req) begin
        m_mode <= 2; m_until <= m_t + 1 + H; m_rr <= 1; m_done <= 0;
      end else if (m_mode == 2 && m_t + 1 == m_until) begin
        m_mode <= 3; m_rr <= 0; m_ack <= 1; m_cnt <= m_cnt + 1;
      end else if (m_mode == 3 && !req) begin
        m_mode <= 1; m_ack <= 0; m_done <= 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("model_rr", rr, m_rr);
    chk("model_done", done, m_done);
    chk("model_ack", ack, m_ack);
    chk("model_cnt", cnt, m_cnt > 255 ? 255 : m_cnt);
    chk("model_rr_sat", rr2, m_rr);
    chk("model_cnt_sat", cnt2, m_cnt > 3 ? 3 : m_cnt);
  end
  task automatic por_check();
    for (int e = 1; e <= P; e++) begin
      @(posedge clk); #1;
      chk("por_rr", rr, e < P ? 1 : 0);
      chk("por_done", done, e < P ? 0 : 1);
      chk("por_ack", ack, 0);
      chk("por_cnt", cnt, 0);
    end
  endtask
  task automatic wait_ack(input string nm);
    int k = 0;
    while (!ack && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, ack, 1);
  endtask
  typedef struct {
    logic req;
    int n;
    logic rr, done, ack;
    int cnt;
  } vec_t;
  vec_t tbl[11];
  int sat_exp[5];
  initial begin
    tbl[0]  = '{1, 1,  1, 0, 0, 0};
    tbl[1]  = '{0, 15, 1, 0, 0, 0};
    tbl[2]  = '{0, 1,  0, 0, 1, 1};
    tbl[3]  = '{0, 1,  0, 1, 0, 1};
    tbl[4]  = '{0, 3,  0, 1, 0, 1};
    tbl[5]  = '{1, 1,  1, 0, 0, 1};
    tbl[6]  = '{1, 15, 1, 0, 0, 1};
    tbl[7]  = '{1, 1,  0, 0, 1, 2};
    tbl[8]  = '{1, 22, 0, 0, 1, 2};
    tbl[9]  = '{0, 1,  0, 1, 0, 2};
    tbl[10] = '{0, 2,  0, 1, 0, 2};
    sat_exp = '{1, 2, 3, 3, 3};
    reset = 1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 0;
    por_check();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) req = tbl[i].req;
      for (int j = 0; j < tbl[i].n; j++) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d_rr", i), rr, tbl[i].rr);
        chk($sformatf("vec%0d_done", i), done, tbl[i].done);
        chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
        chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      end
    end
    @(negedge clk) req = 1;
    @(posedge clk); #1;
    @(negedge clk) req = 0;
    repeat (6) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("mid_hold_rr", rr, 1);
    chk("mid_hold_ack", ack, 0);
    chk("mid_hold_cnt", cnt, 0);
    chk("mid_hold_done", done, 0);
    #2 reset = 0;
    por_check();
    @(negedge clk) req = 1;
    #2 reset = 1;
    #2 reset = 0;
    por_check();
    @(posedge clk); #1;
    chk("por_req_rr", rr, 1);
    chk("por_req_done", done, 0);
    chk("por_req_ack", ack, 0);
    @(negedge clk) req = 0;
    wait_ack("por_req_ack_rise");
    chk("por_req_cnt", cnt, 1);
    @(negedge clk);
    #2 reset = 1;
    #2 reset = 0;
    por_check();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) req = 1;
      @(negedge clk) req = 0;
      wait_ack($sformatf("sat%0d_ack", i));
      chk($sformatf("sat%0d_cnt2", i), cnt2, sat_exp[i]);
      chk($sformatf("sat%0d_cnt", i), cnt, i + 1);
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom % 4 == 0) req = ~req;
      if ($urandom % 400 == 0) begin
        #2 reset = 1;
        #2 reset = 0;
      end else if ($urandom % 700 == 0) begin
        reset = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 0;
      end
    end
    req = 0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/router_reset_ctrl.md
Name: router_reset_ctrl

Overview:
Reset sequencer that sits directly upstream of the router reset interface and produces the single `router_reset` level that the router and its verification agents sample.
- Takes the global asynchronous active-high `reset` and generates `router_reset` with immediate assertion, synchronized deassertion and a guaranteed minimum hold.
- Adds a 4-phase software/testbench soft-reset handshake and a soft-reset event counter.

Parameters:
- SYNC_STAGES, 2, number of deassertion synchronizer flops (>=2)
- HOLD_CYCLES, 16, cycles router_reset stays high after sync release or soft request (>=1)
- CNT_W, 8, width of soft-reset event counter

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high global reset
- sw_rst_req  input  1  soft-reset request, level, 4-phase handshake
- sw_rst_ack  output  1  soft-reset acknowledge
- router_reset  output  1  reset to router (active-high), registered
- reset_done  output  1  high while router is out of reset and idle (RUN)
- sw_rst_count  output  CNT_W  number of completed soft resets, saturating

Behaviour:
- Clock/reset: one clock `clk`; `reset` is asynchronous and active-high. Every flop clears on posedge reset without waiting for clk.
- Reset values (async, immediate): router_reset=1, reset_done=0, sw_rst_ack=0, sw_rst_count=0, sync chain all 0, hold counter 0, state=POR_SYNC.
- States: POR_SYNC, POR_HOLD, RUN, SW_HOLD, SW_ACK.
- POR_SYNC:
  - Sync chain shifts in 1 each edge while reset is low.
  - When the last stage is 1, go to POR_HOLD with counter=0.
- POR_HOLD:
  - Counter increments each edge; router_reset stays 1.
  - When counter reaches HOLD_CYCLES-1, next edge goes to RUN.
- Power-on release timing: router_reset falls on exactly the (SYNC_STAGES+HOLD_CYCLES)-th rising edge, counting the first edge that samples reset low as edge 1. With defaults, that is edge 18. reset_done rises on the same edge.
- RUN: router_reset=0, reset_done=1. If sw_rst_req is sampled 1, the next edge sets router_reset=1 and reset_done=0 and enters SW_HOLD with counter=0.
- SW_HOLD:
  - router_reset=1 for exactly HOLD_CYCLES cycles.
  - On the edge ending the hold: router_reset=0, sw_rst_ack=1, sw_rst_count += 1 (saturates at 2^CNT_W-1), enter SW_ACK.
  - sw_rst_req is ignored here; dropping it early does not shorten the hold.
- SW_ACK:
  - router_reset=0, reset_done=0, sw_rst_ack=1 until sw_rst_req is sampled 0.
  - The next edge drives ack=0 and reset_done=1 and returns to RUN.
  - If req was already low on ack entry, ack is high for exactly 1 cycle.
- sw_rst_req high during POR_SYNC/POR_HOLD: not acknowledged; serviced on the first RUN cycle only if still high.
- reset asserted in any state, including mid soft-reset: immediate return to reset values. A pending handshake is abandoned with ack=0 and the count is cleared.
- reset pulse shorter than one clk period still fully restarts the sequence.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- POR, defaults: hold reset high 5 cycles, deassert mid-cycle -> router_reset=1 until edge 18 after first low sample, then 0; reset_done=1 on the same edge; ack=0 and count=0 throughout.
- Soft reset: in RUN, raise req for 1 cycle -> router_reset high 16 cycles; ack=1 for exactly 1 cycle as router_reset falls; count=1; reset_done back to 1 one edge later.
- Held request: keep req high 40 cycles -> single 16-cycle reset; ack stays 1 until req low, then falls next edge; no second reset; count increments by exactly 1.
- Async reset mid SW_HOLD (cycle 7 of 16), 0.3-period pulse -> router_reset stays 1 with no glitch; ack=0 and count=0 immediately; full 18-edge POR sequence repeats.
- Request during POR: req=1 from time 0 -> no ack before RUN; reset_done pulses 1 for one cycle on RUN entry, then the soft reset starts (SW_HOLD).
- Saturation, CNT_W=2: 5 soft resets -> count reads 1,2,3,3,3.
